// File: rtl/crossbar_if.sv
// rtl/crossbar_if.sv - port bundle for the 5x5 registered crossbar
interface crossbar_if;
  logic [12:0] control0_in;
  logic [12:0] control1_in;
  logic [12:0] control2_in;
  logic [12:0] control3_in;
  logic [12:0] control4_in;
  logic [7:0]  data0_in;
  logic [7:0]  data1_in;
  logic [7:0]  data2_in;
  logic [7:0]  data3_in;
  logic [7:0]  data4_in;
  logic [14:0] route_config;
  logic [12:0] control0_out;
  logic [12:0] control1_out;
  logic [12:0] control2_out;
  logic [12:0] control3_out;
  logic [12:0] control4_out;
  logic [7:0]  data0_out;
  logic [7:0]  data1_out;
  logic [7:0]  data2_out;
  logic [7:0]  data3_out;
  logic [7:0]  data4_out;

  modport master (
    output control0_in, control1_in, control2_in, control3_in, control4_in,
    output data0_in, data1_in, data2_in, data3_in, data4_in,
    output route_config,
    input  control0_out, control1_out, control2_out, control3_out, control4_out,
    input  data0_out, data1_out, data2_out, data3_out, data4_out
  );

  modport slave (
    input  control0_in, control1_in, control2_in, control3_in, control4_in,
    input  data0_in, data1_in, data2_in, data3_in, data4_in,
    input  route_config,
    output control0_out, control1_out, control2_out, control3_out, control4_out,
    output data0_out, data1_out, data2_out, data3_out, data4_out
  );
endinterface

// File: rtl/crossbar.sv
// rtl/crossbar.sv - 5x5 crossbar, lowest input wins contention, registered outputs
module crossbar (
  input  logic       clk,
  input  logic       rst_n,
  crossbar_if.slave  xb
);
  localparam int NPORT = 5;

  logic [12:0] ctrl_in  [NPORT];
  logic [7:0]  data_in  [NPORT];
  logic [2:0]  route    [NPORT];
  logic [12:0] ctrl_nxt [NPORT];
  logic [7:0]  data_nxt [NPORT];
  logic [12:0] ctrl_q   [NPORT];
  logic [7:0]  data_q   [NPORT];

  assign ctrl_in[0] = xb.control0_in;
  assign ctrl_in[1] = xb.control1_in;
  assign ctrl_in[2] = xb.control2_in;
  assign ctrl_in[3] = xb.control3_in;
  assign ctrl_in[4] = xb.control4_in;
  assign data_in[0] = xb.data0_in;
  assign data_in[1] = xb.data1_in;
  assign data_in[2] = xb.data2_in;
  assign data_in[3] = xb.data3_in;
  assign data_in[4] = xb.data4_in;

  for (genvar i = 0; i < NPORT; i++) begin : g_route
    assign route[i] = xb.route_config[3*i +: 3];
  end

  // Route codes 5..7 never equal an output index, so they fall through to zero.
  // Control and data are taken from the same winner index so they stay paired.
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      ctrl_nxt[j] = 13'h0000;
      data_nxt[j] = 8'h00;
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (route[i] == 3'(j)) begin
          ctrl_nxt[j] = ctrl_in[i];
          data_nxt[j] = data_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NPORT; j++) begin
        ctrl_q[j] <= 13'h0000;
        data_q[j] <= 8'h00;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        ctrl_q[j] <= ctrl_nxt[j];
        data_q[j] <= data_nxt[j];
      end
    end
  end

  assign xb.control0_out = ctrl_q[0];
  assign xb.control1_out = ctrl_q[1];
  assign xb.control2_out = ctrl_q[2];
  assign xb.control3_out = ctrl_q[3];
  assign xb.control4_out = ctrl_q[4];
  assign xb.data0_out    = data_q[0];
  assign xb.data1_out    = data_q[1];
  assign xb.data2_out    = data_q[2];
  assign xb.data3_out    = data_q[3];
  assign xb.data4_out    = data_q[4];
endmodule

// File: tb/tb_crossbar.sv
// tb/tb_crossbar.sv - directed self-checking bench for crossbar
module tb_crossbar;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [12:0] exp_c [5];
  logic [7:0]  exp_d [5];

  crossbar_if bus ();

  crossbar dut (
    .clk   (clk),
    .rst_n (rst_n),
    .xb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] get_c(int j);
    case (j)
      0:       return bus.control0_out;
      1:       return bus.control1_out;
      2:       return bus.control2_out;
      3:       return bus.control3_out;
      default: return bus.control4_out;
    endcase
  endfunction

  function automatic logic [7:0] get_d(int j);
    case (j)
      0:       return bus.data0_out;
      1:       return bus.data1_out;
      2:       return bus.data2_out;
      3:       return bus.data3_out;
      default: return bus.data4_out;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [12:0] oc;
    logic [7:0]  od;
    for (int j = 0; j < 5; j++) begin
      oc = get_c(j);
      od = get_d(j);
      checks++;
      assert (oc === exp_c[j]) else begin
        failures++;
        $error("FAIL %s ctrl_out%0d observed=%h expected=%h", tag, j, oc, exp_c[j]);
      end
      checks++;
      assert (od === exp_d[j]) else begin
        failures++;
        $error("FAIL %s data_out%0d observed=%h expected=%h", tag, j, od, exp_d[j]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.control0_in = 13'h1AAA; bus.data0_in = 8'h00;
    bus.control1_in = 13'h1BBB; bus.data1_in = 8'h11;
    bus.control2_in = 13'h1CCC; bus.data2_in = 8'h22;
    bus.control3_in = 13'h1DDD; bus.data3_in = 8'h33;
    bus.control4_in = 13'h1EEE; bus.data4_in = 8'h44;
    bus.route_config = 15'b100_011_010_001_000;

    // Reset holds outputs at zero even across clock edges.
    #1;
    exp_c = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_all("reset");
    step();
    check_all("reset_clocked");
    #3 rst_n = 1'b1;
    #1;
    check_all("release_no_edge");

    bus.route_config = 15'b000_000_000_000_000;
    step();
    exp_c = '{13'h1AAA, 13'h0, 13'h0, 13'h0, 13'h0};
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_all("all_to_out0");

    // Outputs must not follow a route change until the next edge.
    bus.route_config = 15'b100_011_010_001_000;
    #1;
    check_all("latency_hold");
    step();
    exp_c = '{13'h1AAA, 13'h1BBB, 13'h1CCC, 13'h1DDD, 13'h1EEE};
    exp_d = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    check_all("identity");

    bus.route_config = 15'b000_001_010_011_100;
    step();
    exp_c = '{13'h1EEE, 13'h1DDD, 13'h1CCC, 13'h1BBB, 13'h1AAA};
    exp_d = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    check_all("reversal");

    bus.route_config = 15'b001_100_011_000_010;
    step();
    exp_c = '{13'h1BBB, 13'h1EEE, 13'h1AAA, 13'h1CCC, 13'h1DDD};
    exp_d = '{8'h11, 8'h44, 8'h00, 8'h22, 8'h33};
    check_all("permutation");

    bus.route_config = 15'b111_111_111_111_111;
    step();
    exp_c = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_all("all_unrouted");

    bus.route_config = 15'b100_100_100_100_100;
    step();
    exp_c = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h1AAA};
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_all("all_to_out4");

    // in0=5, in1=2, in2=6, in3=2, in4=7: in1 beats in3 on output 2.
    bus.route_config = 15'b111_010_110_010_101;
    step();
    exp_c = '{13'h0, 13'h0, 13'h1BBB, 13'h0, 13'h0};
    exp_d = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h00};
    check_all("contend_invalid");

    // in0->0, in1=5, in2->1, in3->3, in4->1: in2 beats in4 on output 1.
    bus.route_config = 15'b001_011_001_101_000;
    bus.data2_in = 8'h5A;
    bus.data4_in = 8'hA5;
    step();
    exp_c = '{13'h1AAA, 13'h1CCC, 13'h0, 13'h1DDD, 13'h0};
    exp_d = '{8'h00, 8'h5A, 8'h00, 8'h33, 8'h00};
    check_all("contend_low_wins");

    bus.data2_in = 8'h22;
    bus.data4_in = 8'h44;
    bus.route_config = 15'b100_011_010_001_000;
    step();
    exp_c = '{13'h1AAA, 13'h1BBB, 13'h1CCC, 13'h1DDD, 13'h1EEE};
    exp_d = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    check_all("identity_again");

    // Mid-cycle reset clears outputs immediately, then identity returns on the next edge.
    #2 rst_n = 1'b0;
    #1;
    exp_c = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_all("async_reset");
    #2 rst_n = 1'b1;
    #1;
    check_all("post_release");
    step();
    exp_c = '{13'h1AAA, 13'h1BBB, 13'h1CCC, 13'h1DDD, 13'h1EEE};
    exp_d = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    check_all("identity_restored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crossbar.md
CROSSBAR -- requirements
Module: crossbar

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed: 5 ports, 13-bit control, 8-bit data, 3-bit route field per input.
REQ-002 The module SHALL provide port `clk`: input, 1 bit, single clock, rising-edge active.
REQ-003 The module SHALL provide port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL provide ports `control0_in`..`control4_in`: input, 13 bits each, control word of input port i.
REQ-005 The module SHALL provide ports `data0_in`..`data4_in`: input, 8 bits each, data word of input port i.
REQ-006 The module SHALL provide port `route_config`: input, 15 bits; field i = route_config[3i+2:3i] is the destination output index of input i.
REQ-007 The module SHALL provide ports `control0_out`..`control4_out`: output, 13 bits each, registered control word of output port j.
REQ-008 The module SHALL provide ports `data0_out`..`data4_out`: output, 8 bits each, registered data word of output port j.
REQ-009 The module SHALL use one clock (`clk`) with an asynchronous, active-low reset (`rst_n`); these are fixed.

Function
REQ-010 Route field values 0..4 SHALL select output 0..4; values 5, 6 and 7 SHALL mean "not routed", and that input drives no output.
REQ-011 Output j SHALL be claimed by every input i whose route field equals j.
REQ-012 If more than one input claims output j, the lowest-numbered claiming input SHALL win; losing inputs are dropped, with no buffering and no error flag.
REQ-013 Output j SHALL carry the winner's control and data words together as one unit; control and data SHALL never come from different inputs.
REQ-014 An output with no claimant SHALL drive control = 13'h0000 and data = 8'h00.
REQ-015 One input SHALL drive at most one output; there is no multicast.
REQ-016 All outputs SHALL be registered and updated on every rising edge of `clk` from the inputs and `route_config` sampled at that edge; latency is 1 cycle.
REQ-017 There SHALL be no enable and no handshake; the outputs reflect the previous cycle's sampled state every cycle.
REQ-018 The selection logic SHALL be purely combinational ahead of the output registers, and the block SHALL hold no other state.
REQ-019 The block SHALL never pass X or Z to its outputs from the route logic; an unrouted or invalid field falls back to the REQ-014 zeros.

Reset
REQ-020 While `rst_n` = 0, all control*_out SHALL be 13'h0000 and all data*_out SHALL be 8'h00, asynchronously and immediately.
REQ-021 On release of `rst_n`, the first rising edge of `clk` SHALL load routed values per REQ-016.
REQ-022 Reset asserted mid-operation SHALL clear all outputs at once, overriding any clock edge.

Verification
REQ-023 Scenario, all inputs to output 0: inputs ctrl 1AAA/1BBB/1CCC/1DDD/1EEE, data 00/11/22/33/44, route_config = 15'b000_000_000_000_000 -> after 1 edge, out0 = 1AAA/00; out1..4 = 0000/00.
REQ-024 Scenario, identity: route_config = 15'b100_011_010_001_000 -> out0 = 1AAA/00, out1 = 1BBB/11, out2 = 1CCC/22, out3 = 1DDD/33, out4 = 1EEE/44.
REQ-025 Scenario, reversal: route_config = 15'b000_001_010_011_100 -> out4 = 1AAA/00, out3 = 1BBB/11, out2 = 1CCC/22, out1 = 1DDD/33, out0 = 1EEE/44.
REQ-026 Scenario, permutation: route_config = 15'b001_100_011_000_010 -> out2 = 1AAA/00, out0 = 1BBB/11, out3 = 1CCC/22, out4 = 1DDD/33, out1 = 1EEE/44.
REQ-027 Scenario, all unrouted: route_config = 15'b111_111_111_111_111 -> all outputs 0000/00 after 1 edge; also all fields = 3'b100 -> out4 = 1AAA/00 and the others are zero.
REQ-028 Scenario, reset: assert `rst_n` = 0 between clock edges during identity routing -> all outputs zero immediately; after release, the next rising edge restores identity values.
